// File: rtl/conc_stim_sequencer.sv
// Stimulus sequencer: stores up to DEPTH vectors and replays one per clock under start/stop/hold.
// Optional feature macro SEQ_LOOP_EN: continuous replay that wraps to slot 0 and counts wraps.
module conc_stim_sequencer #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 3,
  parameter int AW    = 3,
  parameter int PC_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [AW:0]      cfg_len,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_valid,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [PC_W-1:0]  wraps
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_t           state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, done_q;

  logic             wr_ok_s;
  logic [AW:0]      len_clamp_s;
  logic [PC_W-1:0]  len_ext_s;
  logic [WIDTH-1:0] first_vec_s;

  assign wr_ok_s     = cfg_we && (state_q != RUN) && ({1'b0, cfg_addr} < DEPTH_L);
  assign len_clamp_s = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign len_ext_s   = PC_W'(len_q);
  // A same-edge write to slot 0 must be seen by a start on that edge.
  assign first_vec_s = (wr_ok_s && (cfg_addr == '0)) ? cfg_data : mem_q[0];

`ifdef SEQ_LOOP_EN
  logic [PC_W-1:0] wraps_q, wraps_d;
`endif

  // Vector storage; deliberately not reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_ok_s) begin
      mem_q[cfg_addr] <= cfg_data;
    end
  end

  // Next-state and output logic, priority stop > start > hold > advance.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    vec_d   = vec_q;
    valid_d = 1'b0;
    err_d   = cfg_we && !wr_ok_s;
`ifdef SEQ_LOOP_EN
    wraps_d = wraps_q;
`endif
    if (stop) begin
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      len_d = len_clamp_s;
`ifdef SEQ_LOOP_EN
      wraps_d = '0;
`endif
      if (len_clamp_s == '0) begin
        state_d = DONE;
        pc_d    = '0;
      end else begin
        state_d = RUN;
        vec_d   = first_vec_s;
        valid_d = 1'b1;
        pc_d    = PC_W'(1);
      end
    end else if ((state_q == RUN) && !hold) begin
      if (pc_q < len_ext_s) begin
        vec_d   = mem_q[pc_q[AW-1:0]];
        valid_d = 1'b1;
        pc_d    = pc_q + PC_W'(1);
      end else begin
`ifdef SEQ_LOOP_EN
        vec_d   = mem_q[0];
        valid_d = 1'b1;
        pc_d    = PC_W'(1);
        wraps_d = (wraps_q == '1) ? wraps_q : wraps_q + PC_W'(1);
`else
        state_d = DONE;
`endif
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef SEQ_LOOP_EN
  // Wrap counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wraps_q <= '0;
    end else begin
      wraps_q <= wraps_d;
    end
  end
  assign wraps = wraps_q;
`else
  assign wraps = '0;
`endif

  assign vec_out   = vec_q;
  assign vec_valid = valid_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule
